// File: rtl/of_match_arbiter.sv
// Pairs exact and wildcard lookup results per packet and emits one action per packet.
// Define OF_MATCH_ARB_MISS_TO_CPU_EN to send misses to the CPU port instead of a null action.

`ifndef OF_ACTION_DATA_WIDTH
`define OF_ACTION_DATA_WIDTH 64
`endif
`ifndef OF_ACTION_CTRL_WIDTH
`define OF_ACTION_CTRL_WIDTH 16
`endif
`ifndef OF_DST_PORT_POS
`define OF_DST_PORT_POS 0
`endif
`ifndef OF_DST_PORT
`define OF_DST_PORT 16
`endif

module of_match_arb_fifo #(
    parameter int W          = 8,
    parameter int DEPTH_BITS = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         empty,
    output logic         nearly_full
);
    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [W-1:0]          mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BITS:0]   count_q, count_d;
    logic                  nearly_full_q, nearly_full_d;
    logic                  wr_ok, rd_ok;

    always_comb begin
        wr_ok    = wr_en && (count_q != (DEPTH_BITS+1)'(DEPTH));
        rd_ok    = rd_en && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + DEPTH_BITS'(1);
        if (rd_ok) rd_ptr_d = rd_ptr_q + DEPTH_BITS'(1);
        if (wr_ok && !rd_ok) count_d = count_q + (DEPTH_BITS+1)'(1);
        else if (rd_ok && !wr_ok) count_d = count_q - (DEPTH_BITS+1)'(1);
        // Flag from next occupancy so the engine sees it the cycle after its write
        nearly_full_d = (count_d >= (DEPTH_BITS+1)'(DEPTH - 1));
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            nearly_full_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            nearly_full_q <= nearly_full_d;
        end
    end

    assign rd_data     = mem[rd_ptr_q];
    assign empty       = (count_q == '0);
    assign nearly_full = nearly_full_q;
endmodule

module of_match_arbiter #(
    parameter int                      DATA_W     = `OF_ACTION_DATA_WIDTH,
    parameter int                      CTRL_W     = `OF_ACTION_CTRL_WIDTH,
    parameter int                      DEPTH_BITS = 2,
    parameter logic [`OF_DST_PORT-1:0] MISS_PORT  = 16'h0002,
    parameter int                      TIMEOUT    = 1023
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] exact_data,
    input  logic [CTRL_W-1:0] exact_ctrl,
    input  logic              exact_valid,
    input  logic              exact_hit,
    input  logic [DATA_W-1:0] wild_data,
    input  logic [CTRL_W-1:0] wild_ctrl,
    input  logic              wild_valid,
    input  logic              wild_hit,
    output logic              exact_nearly_full,
    output logic              wild_nearly_full,
    output logic [DATA_W-1:0] action_data_bus,
    output logic [CTRL_W-1:0] action_ctrl_bus,
    output logic              action_valid,
    output logic              action_hit,
    input  logic              action_fifo_nearly_full,
    output logic [31:0]       exact_hit_cnt,
    output logic [31:0]       wild_hit_cnt,
    output logic [31:0]       miss_cnt,
    output logic              sync_err
);
    localparam int W      = 1 + CTRL_W + DATA_W;
    localparam int WAIT_W = $clog2(TIMEOUT + 2);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EMIT  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [W-1:0]      e_rd_data, w_rd_data;
    logic              e_empty, w_empty, e_rd, w_rd;
    logic [1:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              pop_pair, pair_ok, one_pending;
    logic              sync_err_q, sync_err_d;
    logic              action_valid_q, action_valid_d, action_hit_q, action_hit_d;
    logic [DATA_W-1:0] action_data_q, action_data_d, sel_data, miss_data;
    logic [CTRL_W-1:0] action_ctrl_q, action_ctrl_d, sel_ctrl, miss_ctrl;
    logic [31:0]       exact_cnt_q, exact_cnt_d, wild_cnt_q, wild_cnt_d, miss_cnt_q, miss_cnt_d;
    logic              e_hit, w_hit;

    of_match_arb_fifo #(.W(W), .DEPTH_BITS(DEPTH_BITS)) u_exact_fifo (
        .clk(clk), .reset_n(reset_n),
        .wr_en(exact_valid), .wr_data({exact_hit, exact_ctrl, exact_data}),
        .rd_en(e_rd), .rd_data(e_rd_data), .empty(e_empty), .nearly_full(exact_nearly_full)
    );

    of_match_arb_fifo #(.W(W), .DEPTH_BITS(DEPTH_BITS)) u_wild_fifo (
        .clk(clk), .reset_n(reset_n),
        .wr_en(wild_valid), .wr_data({wild_hit, wild_ctrl, wild_data}),
        .rd_en(w_rd), .rd_data(w_rd_data), .empty(w_empty), .nearly_full(wild_nearly_full)
    );

    always_comb begin
        pair_ok     = !e_empty && !w_empty && !action_fifo_nearly_full;
        one_pending = (e_empty != w_empty);
        state_d     = state_q;
        wait_d      = wait_q;
        pop_pair    = 1'b0;
        e_rd        = 1'b0;
        w_rd        = 1'b0;
        sync_err_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pair_ok) begin
                    pop_pair = 1'b1;
                    state_d  = ST_EMIT;
                    wait_d   = '0;
                end else if (one_pending) begin
                    if (wait_q >= WAIT_W'(TIMEOUT)) begin
                        state_d    = ST_FLUSH;
                        sync_err_d = 1'b1;
                        wait_d     = '0;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end else begin
                    wait_d = '0;
                end
            end
            ST_EMIT: begin
                wait_d = '0;
                if (pair_ok) pop_pair = 1'b1;
                else state_d = ST_IDLE;
            end
            ST_FLUSH: begin
                // Results that lost their partner are discarded, including late arrivals
                wait_d = '0;
                e_rd   = !e_empty;
                w_rd   = !w_empty;
                if (e_empty && w_empty) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (pop_pair) begin
            e_rd = 1'b1;
            w_rd = 1'b1;
        end
    end

    always_comb begin
        miss_data = '0;
        miss_ctrl = '0;
`ifdef OF_MATCH_ARB_MISS_TO_CPU_EN
        miss_ctrl = CTRL_W'(1);
        miss_data[`OF_DST_PORT_POS +: `OF_DST_PORT] = MISS_PORT;
`endif
        e_hit = e_rd_data[W-1];
        w_hit = w_rd_data[W-1];
        if (e_hit) begin
            sel_data = e_rd_data[DATA_W-1:0];
            sel_ctrl = e_rd_data[DATA_W +: CTRL_W];
        end else if (w_hit) begin
            sel_data = w_rd_data[DATA_W-1:0];
            sel_ctrl = w_rd_data[DATA_W +: CTRL_W];
        end else begin
            sel_data = miss_data;
            sel_ctrl = miss_ctrl;
        end
    end

    always_comb begin
        action_valid_d = pop_pair;
        action_data_d  = action_data_q;
        action_ctrl_d  = action_ctrl_q;
        action_hit_d   = action_hit_q;
        exact_cnt_d    = exact_cnt_q;
        wild_cnt_d     = wild_cnt_q;
        miss_cnt_d     = miss_cnt_q;
        if (pop_pair) begin
            action_data_d = sel_data;
            action_ctrl_d = sel_ctrl;
            action_hit_d  = e_hit || w_hit;
            if (e_hit) begin
                if (exact_cnt_q != '1) exact_cnt_d = exact_cnt_q + 32'd1;
            end else if (w_hit) begin
                if (wild_cnt_q != '1) wild_cnt_d = wild_cnt_q + 32'd1;
            end else begin
                if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            wait_q         <= '0;
            sync_err_q     <= 1'b0;
            action_valid_q <= 1'b0;
            action_hit_q   <= 1'b0;
            action_data_q  <= '0;
            action_ctrl_q  <= '0;
            exact_cnt_q    <= '0;
            wild_cnt_q     <= '0;
            miss_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            wait_q         <= wait_d;
            sync_err_q     <= sync_err_d;
            action_valid_q <= action_valid_d;
            action_hit_q   <= action_hit_d;
            action_data_q  <= action_data_d;
            action_ctrl_q  <= action_ctrl_d;
            exact_cnt_q    <= exact_cnt_d;
            wild_cnt_q     <= wild_cnt_d;
            miss_cnt_q     <= miss_cnt_d;
        end
    end

    assign action_valid    = action_valid_q;
    assign action_hit      = action_hit_q;
    assign action_data_bus = action_data_q;
    assign action_ctrl_bus = action_ctrl_q;
    assign exact_hit_cnt   = exact_cnt_q;
    assign wild_hit_cnt    = wild_cnt_q;
    assign miss_cnt        = miss_cnt_q;
    assign sync_err        = sync_err_q;
endmodule

// File: tb/tb_of_match_arbiter.sv
// Bench for of_match_arbiter: directed scenarios plus random traffic against a pairing queue model.
// Miss expectations follow OF_MATCH_ARB_MISS_TO_CPU_EN.

`ifndef OF_ACTION_DATA_WIDTH
`define OF_ACTION_DATA_WIDTH 64
`endif
`ifndef OF_ACTION_CTRL_WIDTH
`define OF_ACTION_CTRL_WIDTH 16
`endif
`ifndef OF_DST_PORT_POS
`define OF_DST_PORT_POS 0
`endif
`ifndef OF_DST_PORT
`define OF_DST_PORT 16
`endif

module tb_of_match_arbiter;
    localparam int DW      = `OF_ACTION_DATA_WIDTH;
    localparam int CW      = `OF_ACTION_CTRL_WIDTH;
    localparam int WW      = 1 + CW + DW;
    localparam int TIMEOUT = 1023;

    typedef logic [WW-1:0] word_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] exact_data, wild_data, action_data_bus;
    logic [CW-1:0] exact_ctrl, wild_ctrl, action_ctrl_bus;
    logic          exact_valid, exact_hit, wild_valid, wild_hit;
    logic          exact_nearly_full, wild_nearly_full;
    logic          action_valid, action_hit, action_fifo_nearly_full, sync_err;
    logic [31:0]   exact_hit_cnt, wild_hit_cnt, miss_cnt;

    int    vectors = 0;
    int    miscompares = 0;
    word_t exact_q[$];
    word_t wild_q[$];
    int    m_exact = 0, m_wild = 0, m_miss = 0, sync_seen = 0;

    always #5 clk = ~clk;

    of_match_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .exact_data(exact_data), .exact_ctrl(exact_ctrl), .exact_valid(exact_valid), .exact_hit(exact_hit),
        .wild_data(wild_data), .wild_ctrl(wild_ctrl), .wild_valid(wild_valid), .wild_hit(wild_hit),
        .exact_nearly_full(exact_nearly_full), .wild_nearly_full(wild_nearly_full),
        .action_data_bus(action_data_bus), .action_ctrl_bus(action_ctrl_bus),
        .action_valid(action_valid), .action_hit(action_hit),
        .action_fifo_nearly_full(action_fifo_nearly_full),
        .exact_hit_cnt(exact_hit_cnt), .wild_hit_cnt(wild_hit_cnt), .miss_cnt(miss_cnt),
        .sync_err(sync_err)
    );

    function automatic word_t miss_word();
        word_t m = '0;
`ifdef OF_MATCH_ARB_MISS_TO_CPU_EN
        m[DW +: CW] = CW'(1);
        m[`OF_DST_PORT_POS +: `OF_DST_PORT] = 16'h0002;
`endif
        return m;
    endfunction

    // Exact hit wins, then wildcard hit, otherwise the synthesized miss action
    function automatic word_t expected_action(word_t e, word_t w);
        if (e[WW-1]) return e;
        if (w[WW-1]) return w;
        return miss_word();
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (action_valid) begin
                if (exact_q.size() == 0 || wild_q.size() == 0) begin
                    checkOutput("spurious_action", 64'(1), 64'(0));
                end else begin
                    word_t e, w, x;
                    e = exact_q.pop_front();
                    w = wild_q.pop_front();
                    x = expected_action(e, w);
                    if (e[WW-1]) m_exact++;
                    else if (w[WW-1]) m_wild++;
                    else m_miss++;
                    checkOutput("model_data", 64'(action_data_bus), 64'(x[DW-1:0]));
                    checkOutput("model_ctrl", 64'(action_ctrl_bus), 64'(x[DW +: CW]));
                    checkOutput("model_hit", 64'(action_hit), 64'(x[WW-1]));
                    checkOutput("model_exact_cnt", 64'(exact_hit_cnt), 64'(m_exact));
                    checkOutput("model_wild_cnt", 64'(wild_hit_cnt), 64'(m_wild));
                    checkOutput("model_miss_cnt", 64'(miss_cnt), 64'(m_miss));
                end
            end
            if (sync_err) begin
                sync_seen++;
                exact_q.delete();
                wild_q.delete();
            end
        end
    end

    task automatic applyStimulus(input logic ev, input logic eh, input logic [CW-1:0] ec, input logic [DW-1:0] ed,
                                 input logic wv, input logic wh, input logic [CW-1:0] wc, input logic [DW-1:0] wd);
        exact_valid = ev; exact_hit = eh; exact_ctrl = ec; exact_data = ed;
        wild_valid  = wv; wild_hit  = wh; wild_ctrl  = wc; wild_data  = wd;
        if (ev) exact_q.push_back({eh, ec, ed});
        if (wv) wild_q.push_back({wh, wc, wd});
        @(posedge clk);
        #1;
        exact_valid = 1'b0;
        wild_valid  = 1'b0;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic expectLatency(input int lat, input string name);
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            if (i < lat) checkOutput({name, "_early"}, 64'(action_valid), 64'(0));
            else checkOutput({name, "_valid"}, 64'(action_valid), 64'(1));
        end
    endtask

    task automatic realign();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_valid"}, 64'(action_valid), 64'(0));
        checkOutput({name, "_data"}, 64'(action_data_bus), 64'(0));
        checkOutput({name, "_ctrl"}, 64'(action_ctrl_bus), 64'(0));
        checkOutput({name, "_hit"}, 64'(action_hit), 64'(0));
        checkOutput({name, "_enf"}, 64'(exact_nearly_full), 64'(0));
        checkOutput({name, "_wnf"}, 64'(wild_nearly_full), 64'(0));
        checkOutput({name, "_ecnt"}, 64'(exact_hit_cnt), 64'(0));
        checkOutput({name, "_wcnt"}, 64'(wild_hit_cnt), 64'(0));
        checkOutput({name, "_mcnt"}, 64'(miss_cnt), 64'(0));
        checkOutput({name, "_sync"}, 64'(sync_err), 64'(0));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DW-1:0] d;
        int found, waited, nval, es, ws, sync_before;
        reset_n = 1'b0;
        exact_valid = 1'b0; exact_hit = 1'b0; exact_ctrl = '0; exact_data = '0;
        wild_valid  = 1'b0; wild_hit  = 1'b0; wild_ctrl  = '0; wild_data  = '0;
        action_fifo_nearly_full = 1'b0;
        #12;
        checkAllZero("reset");
        realign();
        reset_n = 1'b1;
        realign();

        $display("[TB] exact hit only");
        d = 64'hA5A5_0000_0000_0004;
        applyStimulus(1'b1, 1'b1, CW'(1), d, 1'b1, 1'b0, '0, 64'hDEAD);
        expectLatency(2, "t1");
        checkOutput("t1_data", 64'(action_data_bus), 64'(d));
        checkOutput("t1_hit", 64'(action_hit), 64'(1));
        checkOutput("t1_ecnt", 64'(exact_hit_cnt), 64'(1));
        realign();

        $display("[TB] both hit, wild late");
        d = 64'h1234_5678_9ABC_DEF0;
        applyStimulus(1'b1, 1'b1, CW'(2), d, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("t2_wait", 64'(action_valid), 64'(0));
            realign();
        end
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, CW'(3), 64'hFFFF_0000_FFFF_0000);
        expectLatency(2, "t2");
        checkOutput("t2_data", 64'(action_data_bus), 64'(d));
        checkOutput("t2_wcnt", 64'(wild_hit_cnt), 64'(0));
        checkOutput("t2_ecnt", 64'(exact_hit_cnt), 64'(2));
        realign();

        $display("[TB] double miss");
        applyStimulus(1'b1, 1'b0, CW'(7), 64'h7777, 1'b1, 1'b0, CW'(9), 64'h9999);
        expectLatency(2, "t3");
`ifdef OF_MATCH_ARB_MISS_TO_CPU_EN
        checkOutput("t3_ctrl", 64'(action_ctrl_bus), 64'(1));
        checkOutput("t3_dst", 64'(action_data_bus[`OF_DST_PORT_POS +: `OF_DST_PORT]), 64'h0002);
`else
        checkOutput("t3_ctrl", 64'(action_ctrl_bus), 64'(0));
        checkOutput("t3_data", 64'(action_data_bus), 64'(0));
`endif
        checkOutput("t3_hit", 64'(action_hit), 64'(0));
        checkOutput("t3_mcnt", 64'(miss_cnt), 64'(1));
        realign();

        $display("[TB] backpressure hold");
        action_fifo_nearly_full = 1'b1;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), CW'($urandom()), {$urandom(), $urandom()},
                          1'b1, 1'($urandom_range(0, 1)), CW'($urandom()), {$urandom(), $urandom()});
            checkOutput("t4_hold_valid", 64'(action_valid), 64'(0));
            checkOutput("t4_enf", 64'(exact_nearly_full), 64'(k >= 2));
            checkOutput("t4_wnf", 64'(wild_nearly_full), 64'(k >= 2));
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("t4_hold_valid", 64'(action_valid), 64'(0));
            realign();
        end
        action_fifo_nearly_full = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("t4_release_valid", 64'(action_valid), 64'(i >= 1 && i <= 4));
            realign();
        end
        checkOutput("t4_enf_drained", 64'(exact_nearly_full), 64'(0));

        $display("[TB] pairing timeout");
        sync_before = sync_seen;
        applyStimulus(1'b1, 1'b1, CW'(5), 64'h5555, 1'b0, 1'b0, '0, '0);
        found = 0; waited = 0; nval = 0;
        for (int i = 1; i <= 1100 && found == 0; i++) begin
            @(negedge clk);
            if (action_valid) nval++;
            if (sync_err) begin
                found  = 1;
                waited = i;
            end
        end
        checkOutput("t5_sync_seen", 64'(found), 64'(1));
        checkOutput("t5_waited_enough", 64'(waited >= TIMEOUT), 64'(1));
        realign();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (action_valid) nval++;
            if (sync_err) found++;
            realign();
        end
        checkOutput("t5_single_pulse", 64'(found), 64'(1));
        checkOutput("t5_no_action", 64'(nval), 64'(0));
        checkOutput("t5_model_pulses", 64'(sync_seen - sync_before), 64'(1));
        applyStimulus(1'b1, 1'b0, CW'(4), 64'h4444, 1'b1, 1'b1, CW'(6), 64'h6666);
        expectLatency(2, "t5_after");
        checkOutput("t5_after_data", 64'(action_data_bus), 64'h6666);
        realign();

        $display("[TB] async reset mid-emit");
        applyStimulus(1'b1, 1'b1, CW'(8), 64'h8888, 1'b1, 1'b0, '0, '0);
        expectLatency(2, "t6_pre");
        #2;
        reset_n = 1'b0;
        #1;
        checkAllZero("t6_reset");
        exact_q.delete();
        wild_q.delete();
        m_exact = 0; m_wild = 0; m_miss = 0;
        realign();
        reset_n = 1'b1;
        realign();
        applyStimulus(1'b1, 1'b0, CW'(1), 64'h1111, 1'b1, 1'b1, CW'(2), 64'h2222);
        expectLatency(2, "t6_post");
        checkOutput("t6_post_data", 64'(action_data_bus), 64'h2222);
        checkOutput("t6_post_wcnt", 64'(wild_hit_cnt), 64'(1));
        realign();

        $display("[TB] random traffic");
        sync_before = sync_seen;
        es = 0; ws = 0;
        for (int c = 0; c < 400; c++) begin
            logic ev, wv;
            ev = !exact_nearly_full && ($urandom_range(0, 9) < 4);
            wv = !wild_nearly_full && ($urandom_range(0, 9) < 4);
            action_fifo_nearly_full = ($urandom_range(0, 3) == 0);
            if (ev) es++;
            if (wv) ws++;
            applyStimulus(ev, 1'($urandom_range(0, 1)), CW'($urandom()), {$urandom(), $urandom()},
                          wv, 1'($urandom_range(0, 1)), CW'($urandom()), {$urandom(), $urandom()});
        end
        action_fifo_nearly_full = 1'b0;
        for (int c = 0; c < 60 && es != ws; c++) begin
            logic ev, wv;
            ev = (es < ws) && !exact_nearly_full;
            wv = (ws < es) && !wild_nearly_full;
            if (ev) es++;
            if (wv) ws++;
            applyStimulus(ev, 1'($urandom_range(0, 1)), CW'($urandom()), {$urandom(), $urandom()},
                          wv, 1'($urandom_range(0, 1)), CW'($urandom()), {$urandom(), $urandom()});
        end
        repeat (30) idleCycle();
        checkOutput("rand_balanced", 64'(es == ws), 64'(1));
        checkOutput("rand_exact_drained", 64'(exact_q.size()), 64'(0));
        checkOutput("rand_wild_drained", 64'(wild_q.size()), 64'(0));
        checkOutput("rand_no_sync", 64'(sync_seen - sync_before), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/of_match_arbiter.md
# of_match_arbiter

Merges per-packet lookup results from the exact-match and wildcard lookup engines into the single action stream that feeds the action processor. Each engine returns one result per packet, in packet order but with independent latency. The block pairs the results and selects exact-hit over wildcard-hit. On a miss it synthesizes a default action. It throttles both engines and itself against the action processor's action FIFO.

## Interface
Parameters:
- DATA_W, default `OF_ACTION_DATA_WIDTH: action data bus width.
- CTRL_W, default `OF_ACTION_CTRL_WIDTH: action ctrl (enable bit) width.
- DEPTH_BITS, default 2: log2 depth of each internal result FIFO.
- MISS_PORT, default 16'h0002: one-hot dst-port mask for the miss action (CPU port 0).
- TIMEOUT, default 1023: maximum cycles one result may wait unpaired.

Ports:
- clk, in, 1: core clock.
- reset_n, in, 1: reset, asynchronous, active-low.
- exact_data, in, DATA_W: exact-engine action data.
- exact_ctrl, in, CTRL_W: exact-engine action ctrl.
- exact_valid, in, 1: exact result strobe, one cycle per packet.
- exact_hit, in, 1: exact lookup hit flag.
- wild_data, in, DATA_W: wildcard-engine action data.
- wild_ctrl, in, CTRL_W: wildcard-engine action ctrl.
- wild_valid, in, 1: wildcard result strobe, one cycle per packet.
- wild_hit, in, 1: wildcard lookup hit flag.
- exact_nearly_full, out, 1: exact FIFO has ≤1 free entry; engine must stall.
- wild_nearly_full, out, 1: wildcard FIFO has ≤1 free entry; engine must stall.
- action_data_bus, out, DATA_W: selected action data.
- action_ctrl_bus, out, CTRL_W: selected action ctrl.
- action_valid, out, 1: one-cycle strobe per packet.
- action_hit, out, 1: 1 if either engine hit.
- action_fifo_nearly_full, in, 1: downstream backpressure.
- exact_hit_cnt, out, 32: exact-hit counter, saturating.
- wild_hit_cnt, out, 32: wildcard-only-hit counter, saturating.
- miss_cnt, out, 32: miss counter, saturating.
- sync_err, out, 1: one-cycle pulse on pairing timeout.

## Operation
- Each engine writes into its own fallthrough FIFO on its `*_valid` strobe. Words are {hit, ctrl, data}.
- A write to a full FIFO is dropped. That condition is a protocol violation and is not otherwise flagged.
- The state machine has three states: IDLE, EMIT, FLUSH.
- IDLE:
  - If both FIFOs are non-empty and action_fifo_nearly_full=0, pop both and go to EMIT.
  - Otherwise, while exactly one FIFO is non-empty, increment the wait counter. Clear the wait counter whenever that condition is false.
  - When the wait counter reaches TIMEOUT, go to FLUSH.
- EMIT:
  - Register the outputs and assert action_valid for one cycle.
  - Return to IDLE. If a pair is ready and there is no backpressure, pop and remain in EMIT instead (back-to-back, one action per cycle).
- Selection, in priority order:
  - Exact hit: output exact_data/exact_ctrl, hit=1, increment exact_hit_cnt.
  - Else wildcard hit: output wild_data/wild_ctrl, hit=1, increment wild_hit_cnt.
  - Else miss: output the miss action (see Configuration), hit=0, increment miss_cnt.
- FLUSH:
  - Pop every non-empty FIFO each cycle until both are empty.
  - Pulse sync_err in the first FLUSH cycle.
  - Clear the wait counter and return to IDLE.
  - Writes arriving during FLUSH are accepted and flushed too.
- Counters saturate at 32'hFFFFFFFF.
- Simultaneous write and pop on the same FIFO is legal; occupancy is unchanged.

## Timing
- Reset values, with reset_n low:
  - All outputs are 0.
  - Both FIFOs are empty.
  - State is IDLE.
  - Counters are 0.
  - The wait counter is 0.
- Reset asserted mid-operation discards all pending results immediately.
- Latency: the later of the two `*_valid` strobes is in cycle N; the FIFO shows non-empty in N+1; the pop happens in N+1; action_valid is asserted in N+2.
- action_fifo_nearly_full is sampled in the pop cycle only. An action already registered is always emitted.
- `*_nearly_full` is registered from occupancy and is valid the cycle after the write.
- Action outputs hold their last value while action_valid=0. Only action_valid=1 marks them as meaningful.

## Configuration
- OF_MATCH_ARB_MISS_TO_CPU_EN defined:
  - The miss action has ctrl bit 0 set.
  - action_data_bus[`OF_DST_PORT_POS +: `OF_DST_PORT] = MISS_PORT.
  - All other bits are 0.
- Not defined:
  - The miss action has ctrl=0 and data=0, so the action processor forwards the packet unmodified.
  - miss_cnt still counts.

## Test plan
- Exact hit only: exact_valid with hit=1, ctrl=1, dst=0x0004, and wild_valid with hit=0 in the same cycle -> action_valid two cycles later, data=exact_data, hit=1, exact_hit_cnt=1.
- Both hit, with wild arriving 5 cycles after exact -> one action_valid, 2 cycles after wild_valid, carrying exact_data; wild_hit_cnt stays 0.
- Double miss with the macro defined -> ctrl=1, dst field=0x0002, hit=0, miss_cnt=1. Repeat with the macro undefined -> ctrl=0, data=0.
- Four pairs back-to-back with action_fifo_nearly_full held high for 10 cycles -> no action_valid during the hold, four consecutive action_valid cycles after release, and `*_nearly_full` asserted while FIFOs hold ≥3 entries.
- Timeout: a single exact_valid with no wild result for TIMEOUT=1023 cycles -> sync_err pulses once, the FIFO empties, and no action_valid. A following matched pair then emits normally.
- Async reset asserted mid-EMIT, between clock edges -> all outputs 0 immediately. After release, a fresh pair produces action_valid after the standard 2-cycle latency.
